quad_correct_stage: RTL
=======================

QUAD_CORRECT_STAGE -- requirements
Module: quad_correct_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, the upstream scale-free block presents a sample.
REQ-004 SHALL have port in_ready, output, 1, this stage accepts the sample this cycle.
REQ-005 SHALL have ports d1, d0, input, 1 each, quadrant code carried alongside the sample (d1_o/d0_o of the scale-free block).
REQ-006 SHALL have ports x_in, y_in, input, 16 each, signed two's-complement Q2.14 rotated vector (Xout/Yout of the scale-free block).
REQ-007 SHALL have port out_valid, output, 1, corrected sample available.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the sample.
REQ-009 SHALL have ports cos_out, sin_out, output, 16 each, signed Q2.14 quadrant-corrected result.
REQ-010 SHALL have port sat_out, output, 1, the presented sample saturated during negation.
REQ-011 SHALL have port sat_cnt, output, 8, count of saturated samples delivered.
REQ-012 SHALL have port sat_clr, input, 1, synchronous clear of sat_cnt.

Function
REQ-013 SHALL transfer input when in_valid and in_ready are both 1; output transfers when out_valid and out_ready are both 1.
REQ-014 SHALL be a two-register pipeline: S1 captures {d1,d0,x_in,y_in}; S2 holds the corrected result, which drives cos_out, sin_out and sat_out directly.
REQ-015 SHALL use advance rules adv2 = !s2_valid | out_ready and adv1 = adv2, with in_ready = !s1_valid | adv1; these rules are purely combinational from state and out_ready.
REQ-016 SHALL deliver an accepted sample with out_valid at the second rising edge after acceptance when not stalled (latency 2), and sustain one sample per cycle.
REQ-017 SHALL hold cos_out, sin_out, sat_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL load each stage's valid from the upstream valid on advance; no sample is dropped or duplicated.
REQ-019 SHALL map d1d0 as follows: 00 gives cos=x, sin=y; 01 gives cos=-y, sin=x; 10 gives cos=-x, sin=-y; 11 gives cos=y, sin=-x.
REQ-020 SHALL saturate negation of 0x8000 to 0x7FFF and set sat_out=1 for that sample; sat_out=0 otherwise.
REQ-021 SHALL increment sat_cnt on each output transfer with sat_out=1, holding at 255 with no wrap.
REQ-022 SHALL give sat_clr priority over an increment in the same cycle (result 0).
REQ-023 SHALL compute the S2 datapath from S1 contents only; there is no combinational path from x_in/y_in to the outputs.

Reset
REQ-024 SHALL, while rst_n=0, force out_valid=0, cos_out=0, sin_out=0, sat_out=0, sat_cnt=0 and clear both stage valids, asynchronously.
REQ-025 SHALL report in_ready=1 from the first cycle after rst_n deasserts.
REQ-026 SHALL discard in-flight samples on reset asserted mid-operation; none appear after release.

Verification
REQ-027 Reset check: assert rst_n=0 mid-stream -> out_valid=0, sat_cnt=0 immediately, without waiting for a clock edge.
REQ-028 Quadrant 01: x=0x2D41, y=0x2D41, out_ready=1 -> two edges later cos=0xD2BF, sin=0x2D41, sat_out=0.
REQ-029 Saturation: d1d0=10, x=0x8000, y=0x1000 -> cos=0x7FFF, sin=0xF000, sat_out=1, sat_cnt 0->1 on transfer.
REQ-030 Back-pressure: stream 4 samples with out_ready=0 for 5 cycles -> out_valid held, in_ready=0 once both stages are full; after release all 4 are delivered in order, unchanged.
REQ-031 Counter limits: 300 saturating samples -> sat_cnt=255; sat_clr together with a saturating transfer -> sat_cnt=0.
REQ-032 Throughput: 100 random samples with in_valid and out_ready held 1 -> 100 outputs on consecutive cycles, each matching the REQ-019/020 model.

Source files
------------

// File: rtl/quad_correct_stage.sv
// ----------------------------------------------------------------------------
// quad_correct_stage
//
// Purpose:
//   Output stage of a scale-free rotator. The rotator works only within the
//   first quadrant and passes a 2-bit quadrant code {d1,d0} alongside each
//   rotated vector. This stage folds the vector back into the requested
//   quadrant by swapping and negating components:
//     d1d0 = 00 : cos =  x, sin =  y
//     d1d0 = 01 : cos = -y, sin =  x
//     d1d0 = 10 : cos = -x, sin = -y
//     d1d0 = 11 : cos =  y, sin = -x
//   Negating the most negative Q2.14 value (0x8000) cannot be represented, so
//   it saturates to 0x7FFF and the sample is flagged with sat_out. Flagged
//   samples are counted in a saturating 8-bit counter.
//
//   Two-register valid/ready pipeline:
//     S1 captures {d1,d0,x_in,y_in}
//     S2 holds the corrected result and drives the outputs directly
//   so there is no combinational path from x_in/y_in to the outputs.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   upstream presents a sample
//   in_ready   out  1   this stage accepts the sample this cycle
//   d1, d0     in   1   quadrant code
//   x_in,y_in  in   16  signed Q2.14 rotated vector
//   out_valid  out  1   corrected sample available
//   out_ready  in   1   downstream accepts the sample
//   cos_out    out  16  signed Q2.14 corrected cosine
//   sin_out    out  16  signed Q2.14 corrected sine
//   sat_out    out  1   the presented sample saturated during negation
//   sat_cnt    out  8   count of delivered saturated samples (holds at 255)
//   sat_clr    in   1   synchronous clear of sat_cnt (wins over increment)
// ----------------------------------------------------------------------------
module quad_correct_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        d1,
    input  logic        d0,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] cos_out,
    output logic [15:0] sin_out,
    output logic        sat_out,
    output logic [7:0]  sat_cnt,
    input  logic        sat_clr
);

    // Two's-complement negation with saturation.
    // Returns {saturated, value}; only 0x8000 saturates (to 0x7FFF).
    function automatic logic [16:0] sat_neg(input logic [15:0] v);
        logic [16:0] r;
        if (v == 16'h8000) begin
            r = {1'b1, 16'h7FFF};
        end else begin
            r = {1'b0, 16'h0000 - v};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_quad_q,  s1_quad_d;
    logic [15:0] s1_x_q,     s1_x_d;
    logic [15:0] s1_y_q,     s1_y_d;

    logic        s2_valid_q, s2_valid_d;
    logic [15:0] s2_cos_q,   s2_cos_d;
    logic [15:0] s2_sin_q,   s2_sin_d;
    logic        s2_sat_q,   s2_sat_d;

    logic [7:0]  sat_cnt_q,  sat_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        adv1_s;
    logic        adv2_s;
    logic        in_ready_s;
    logic [16:0] neg_x_s;
    logic [16:0] neg_y_s;
    logic [15:0] corr_cos_s;
    logic [15:0] corr_sin_s;
    logic        corr_sat_s;
    logic        out_xfer_s;

    // Advance rules: S2 moves when empty or drained; S1 moves with S2.
    always_comb begin
        adv2_s     = (~s2_valid_q) | out_ready;
        adv1_s     = adv2_s;
        in_ready_s = (~s1_valid_q) | adv1_s;
    end

    // Stage-1 capture: load the upstream valid (and data on a real sample)
    // whenever this stage can accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_quad_d  = s1_quad_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        if (in_ready_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_quad_d = {d1, d0};
                s1_x_d    = x_in;
                s1_y_d    = y_in;
            end else begin
                s1_quad_d = s1_quad_q;
                s1_x_d    = s1_x_q;
                s1_y_d    = s1_y_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Quadrant correction computed purely from S1 contents.
    always_comb begin
        neg_x_s    = sat_neg(s1_x_q);
        neg_y_s    = sat_neg(s1_y_q);
        corr_cos_s = s1_x_q;
        corr_sin_s = s1_y_q;
        corr_sat_s = 1'b0;
        case (s1_quad_q)
            2'b00: begin
                corr_cos_s = s1_x_q;
                corr_sin_s = s1_y_q;
                corr_sat_s = 1'b0;
            end
            2'b01: begin
                corr_cos_s = neg_y_s[15:0];
                corr_sin_s = s1_x_q;
                corr_sat_s = neg_y_s[16];
            end
            2'b10: begin
                corr_cos_s = neg_x_s[15:0];
                corr_sin_s = neg_y_s[15:0];
                corr_sat_s = neg_x_s[16] | neg_y_s[16];
            end
            2'b11: begin
                corr_cos_s = s1_y_q;
                corr_sin_s = neg_x_s[15:0];
                corr_sat_s = neg_x_s[16];
            end
            default: begin
                corr_cos_s = s1_x_q;
                corr_sin_s = s1_y_q;
                corr_sat_s = 1'b0;
            end
        endcase
    end

    // Stage-2 capture: take S1's valid on advance; data only moves when a
    // real sample advances so a stalled output stays bit-stable.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_cos_d   = s2_cos_q;
        s2_sin_d   = s2_sin_q;
        s2_sat_d   = s2_sat_q;
        if (adv2_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_cos_d = corr_cos_s;
                s2_sin_d = corr_sin_s;
                s2_sat_d = corr_sat_s;
            end else begin
                s2_cos_d = s2_cos_q;
                s2_sin_d = s2_sin_q;
                s2_sat_d = s2_sat_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Saturation counter: clear beats increment, increment stops at 255.
    always_comb begin
        out_xfer_s = s2_valid_q & out_ready;
        sat_cnt_d  = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = 8'd0;
        end else if (out_xfer_s && s2_sat_q && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Pipeline and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_quad_q  <= 2'b00;
            s1_x_q     <= 16'h0000;
            s1_y_q     <= 16'h0000;
            s2_valid_q <= 1'b0;
            s2_cos_q   <= 16'h0000;
            s2_sin_q   <= 16'h0000;
            s2_sat_q   <= 1'b0;
            sat_cnt_q  <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_quad_q  <= s1_quad_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_cos_q   <= s2_cos_d;
            s2_sin_q   <= s2_sin_d;
            s2_sat_q   <= s2_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    // Outputs come straight from S2 flops; in_ready is the only
    // combinational output (from state and out_ready).
    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign cos_out   = s2_cos_q;
    assign sin_out   = s2_sin_q;
    assign sat_out   = s2_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule
